booth_iter_counter: RTL and testbench

//  Parametrised iteration counter/sequencer for the Booth multiplier datapath.
//  A start pulse launches a run of (term+1) steps. The count advances up or down on each step strobe.

---
 rtl/booth_iter_counter_if.sv | 36 +++
 rtl/booth_iter_counter.sv | 88 ++++++++
 tb/tb_booth_iter_counter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/booth_iter_counter_if.sv
// Control/status bundle between the Booth control FSM and the iteration counter.
//   master : control FSM side, drives start/abort/step/dir/term and
//            observes count/busy/last/done.
//   slave  : counter side, the mirror of master.
//   start  : launch a run (sampled only when the counter is idle or done)
//   abort  : cancel a run in progress, no done pulse
//   step   : advance-count strobe, effective only while running
//   dir    : 0 = count up 0..term, 1 = count down term..0 (captured on start)
//   term   : terminal value, i.e. number of steps minus 1 (captured on start)
//   count  : current iteration index
//   busy   : run in progress
//   last   : the current step is the final one of the run
//   done   : one-cycle pulse after the final step
interface booth_iter_counter_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             abort;
  logic             step;
  logic             dir;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             last;
  logic             done;

  modport master (
    output start, abort, step, dir, term,
    input  count, busy, last, done
  );

  modport slave (
    input  start, abort, step, dir, term,
    output count, busy, last, done
  );
endinterface

// File: rtl/booth_iter_counter.sv
// Iteration counter/sequencer for the Booth multiplier loop.
// A start launches a run of (term+1) accepted steps, counting up from 0 to
// term or down from term to 0. busy/last/done frame the loop; abort cancels.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : control/status bundle (slave side), see booth_iter_counter_if
module booth_iter_counter #(
  parameter int WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  booth_iter_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] term_reg, term_next;
  logic             dir_reg, dir_next;
  logic [WIDTH-1:0] end_val;

  // The count stops at the end value instead of stepping past it, so a
  // full-range term never overflows.
  assign end_val = dir_reg ? '0 : term_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      term_reg  <= '0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      term_reg  <= term_next;
      dir_reg   <= dir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    term_next  = term_reg;
    dir_next   = dir_reg;
    unique case (state_reg)
      // DONE behaves like IDLE for start, which allows back-to-back runs.
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = RUN;
          term_next  = bus.term;
          dir_next   = bus.dir;
          count_next = bus.dir ? bus.term : '0;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
          count_next = '0;
        end else if (bus.step) begin
          if (count_reg == end_val) begin
            state_next = DONE;
          end else begin
            count_next = dir_reg ? (count_reg - ONE) : (count_reg + ONE);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // All outputs decode registered state only: no input-to-output path.
  assign bus.count = count_reg;
  assign bus.busy  = (state_reg == RUN);
  assign bus.done  = (state_reg == DONE);
  assign bus.last  = (state_reg == RUN) && (count_reg == end_val);

endmodule

// File: tb/tb_booth_iter_counter.sv
// Self-checking bench for booth_iter_counter: directed scenarios followed by
// randomized stimulus, compared each cycle against a run/step-count model.
module tb_booth_iter_counter;

  localparam int WIDTH = 3;

  logic clk;
  logic rst_n;

  booth_iter_counter_if #(.WIDTH(WIDTH)) bus ();

  booth_iter_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 running, 2 done; progress kept as the
  // number of steps accepted so far in the current run.
  int m_phase;
  int m_term;
  int m_dir;
  int m_steps;
  int m_count;
  int prev_done;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_term  = 0;
    m_dir   = 0;
    m_steps = 0;
    m_count = 0;
  endtask

  task automatic model_launch();
    m_phase = 1;
    m_term  = int'(bus.term);
    m_dir   = int'(bus.dir);
    m_steps = 0;
    m_count = m_dir ? m_term : 0;
  endtask

  task automatic model_edge();
    case (m_phase)
      0, 2: begin
        if (bus.start) model_launch();
        else m_phase = 0;
      end
      default: begin
        if (bus.abort) begin
          m_phase = 0;
          m_count = 0;
        end else if (bus.step) begin
          m_steps++;
          if (m_steps == m_term + 1) m_phase = 2;
          else m_count = m_dir ? (m_term - m_steps) : m_steps;
        end
      end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    int exp_busy;
    exp_busy = (m_phase == 1) ? 1 : 0;
    chk({tag, ".count"}, int'(bus.count), m_count);
    chk({tag, ".busy"},  int'(bus.busy),  exp_busy);
    chk({tag, ".done"},  int'(bus.done),  (m_phase == 2) ? 1 : 0);
    chk({tag, ".last"},  int'(bus.last),  (exp_busy == 1 && m_steps == m_term) ? 1 : 0);
  endtask

  // One clock: inputs were set before the edge; model follows the edge and
  // outputs are sampled 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    chk({tag, ".done_twice"}, (prev_done == 1 && bus.done) ? 1 : 0, 0);
    prev_done = int'(bus.done);
  endtask

  task automatic drive(input logic s, input logic a, input logic st,
                       input logic d, input int t);
    bus.start = s;
    bus.abort = a;
    bus.step  = st;
    bus.dir   = d;
    bus.term  = WIDTH'(t);
  endtask

  initial begin
    prev_done = 0;
    model_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    check_outputs("reset");
    #10;
    rst_n = 1'b1;

    // 1: up count, term=7, continuous steps.
    drive(1, 0, 0, 0, 7);
    cycle("s1_start");
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 0, 7);
      cycle("s1_step");
    end
    drive(0, 0, 0, 0, 7);
    cycle("s1_idle");
    cycle("s1_hold");

    // 2: same run, step toggling.
    drive(1, 0, 0, 0, 7);
    cycle("s2_start");
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, (i % 2 == 0), 0, 7);
      cycle("s2_step");
    end
    drive(0, 0, 0, 0, 0);
    cycle("s2_idle");

    // 3: down count, term=5, term/dir scrambled after capture.
    drive(1, 0, 0, 1, 5);
    cycle("s3_start");
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 1'($urandom), int'($urandom_range(0, 7)));
      cycle("s3_step");
    end
    drive(0, 0, 0, 0, 0);
    cycle("s3_idle");

    // 4: start pulsed during RUN, abort at count=3.
    drive(1, 0, 0, 0, 6);
    cycle("s4_start");
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 2);
      cycle("s4_step");
    end
    chk("s4_count_before_abort", int'(bus.count), 3);
    drive(1, 1, 1, 0, 2);
    cycle("s4_abort");
    drive(0, 0, 1, 0, 2);
    for (int i = 0; i < 3; i++) cycle("s4_after");

    // 5: async reset mid-run at count=4.
    drive(1, 0, 0, 0, 7);
    cycle("s5_start");
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 7);
      cycle("s5_step");
    end
    chk("s5_count_before_reset", int'(bus.count), 4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("s5_async_reset");
    #1;
    rst_n = 1'b1;
    drive(1, 0, 0, 1, 2);
    cycle("s5_restart");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0);
      cycle("s5_run");
    end
    drive(0, 0, 0, 0, 0);
    cycle("s5_idle");

    // 6: term=0, then start in the DONE cycle.
    drive(1, 0, 0, 0, 0);
    cycle("s6_start");
    drive(0, 0, 1, 0, 0);
    cycle("s6_step");
    chk("s6_done_pulse", int'(bus.done), 1);
    drive(1, 0, 0, 0, 3);
    cycle("s6_restart");
    chk("s6_busy_again", int'(bus.busy), 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 0);
      cycle("s6_run");
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 24) == 0, ($urandom % 3) != 0,
            1'($urandom), int'($urandom_range(0, 7)));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
